// File: rtl/flit_requester_if.sv
// Handshake bundle between a flit requester and its packet source / arbiter.
// master: the requester side; slave: the source/arbiter side.
interface flit_requester_if #(
  parameter int DATA_W = 32
);
  logic              pkt_valid;
  logic [11:0]       pkt_length;
  logic              pkt_ready;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic [DATA_W-1:0] flit_out;
  logic              flit_valid;
  logic [15:0]       stall_cnt;

  modport master (
    input  pkt_valid, pkt_length, data_in, data_valid, grant,
    output pkt_ready, data_ready, req, flit_id, length, flit_out, flit_valid, stall_cnt
  );

  modport slave (
    output pkt_valid, pkt_length, data_in, data_valid, grant,
    input  pkt_ready, data_ready, req, flit_id, length, flit_out, flit_valid, stall_cnt
  );
endinterface

// File: rtl/flit_requester.sv
// Packet-to-flit requester: accepts a descriptor, requests the arbiter and emits tagged flits.
// Optional grant-wait counter on stall_cnt when FLIT_REQ_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a packet descriptor (pkt_ready=1)
// REQ   | requesting the arbiter, no grant held yet
// SEND  | granted, moving one flit per valid data beat
module flit_requester #(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  flit_requester_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t      state;
  logic [11:0] len_q;
  logic [11:0] idx;
  logic        xfer;
  logic        is_tail;

  assign bus.pkt_ready  = (state == IDLE);
  assign bus.data_ready = (state == SEND) && bus.grant;
  assign xfer           = bus.data_ready && bus.data_valid;
  assign is_tail        = (idx == len_q - 12'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len_q          <= 12'd0;
      idx            <= 12'd0;
      bus.req        <= 1'b0;
      bus.flit_valid <= 1'b0;
      bus.flit_id    <= 3'b000;
      bus.length     <= 12'd0;
      bus.flit_out   <= {DATA_W{1'b0}};
    end else begin
      bus.flit_valid <= xfer;
      if (xfer) begin
        bus.flit_out <= bus.data_in;
        bus.length   <= len_q;
        // Length is clamped to >= 2, so index 0 can never also be the tail.
        if (idx == 12'd0)  bus.flit_id <= 3'b001;
        else if (is_tail)  bus.flit_id <= 3'b100;
        else               bus.flit_id <= 3'b010;
      end else begin
        bus.flit_id <= 3'b000;
        bus.length  <= 12'd0;
      end

      case (state)
        IDLE: begin
          if (bus.pkt_valid) begin
            len_q   <= (bus.pkt_length < 12'd2) ? 12'd2 : bus.pkt_length;
            idx     <= 12'd0;
            bus.req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.grant) state <= SEND;
        end
        SEND: begin
          // Losing grant keeps idx and req so the packet resumes where it stopped.
          if (!bus.grant) begin
            state <= REQ;
          end else if (xfer) begin
            if (is_tail) begin
              bus.req <= 1'b0;
              state   <= IDLE;
            end else begin
              idx <= idx + 12'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLIT_REQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else if (bus.pkt_ready && bus.pkt_valid) begin
      stall_q <= 16'h0000;
    end else if (bus.req && !bus.grant && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_flit_requester.sv
// Directed bench for flit_requester: normal packets, length clamp, grant loss,
// mid-packet reset, data stalls and the grant-wait counter.
module tb_flit_requester;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flit_requester_if #(.DATA_W(DATA_W)) bus ();

  flit_requester #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_id(input int idx, input int len);
    if (idx == 0)            return 3'b001;
    else if (idx == len - 1) return 3'b100;
    else                     return 3'b010;
  endfunction

  task automatic accept(input logic [11:0] len);
    bus.pkt_valid  = 1'b1;
    bus.pkt_length = len;
    check("pkt_ready_idle", bus.pkt_ready, 1);
    cycle();
    bus.pkt_valid = 1'b0;
    check("req_after_accept", bus.req, 1);
    check("pkt_ready_busy", bus.pkt_ready, 0);
  endtask

  task automatic grant_to_send();
    bus.grant      = 1'b1;
    bus.data_valid = 1'b1;
    cycle();
    check("data_ready_send", bus.data_ready, 1);
    check("no_flit_on_grant", bus.flit_valid, 0);
  endtask

  task automatic run_flits(input int first, input int n, input int len, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.data_in = base + 32'(first + i);
      cycle();
      check("flit_valid", bus.flit_valid, 1);
      check("flit_id", bus.flit_id, exp_id(first + i, len));
      check("length", bus.length, len);
      check("flit_out", bus.flit_out, base + 32'(first + i));
    end
  endtask

  task automatic tail_done(input logic [31:0] last_data);
    check("req_after_tail", bus.req, 0);
    check("pkt_ready_after_tail", bus.pkt_ready, 1);
    bus.grant      = 1'b0;
    bus.data_valid = 1'b0;
    cycle();
    check("idle_flit_valid", bus.flit_valid, 0);
    check("idle_flit_id", bus.flit_id, 0);
    check("idle_length", bus.length, 0);
    check("flit_out_hold", bus.flit_out, last_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pkt_valid  = 1'b0;
    bus.pkt_length = 12'd0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.grant      = 1'b0;

    rst = 1'b1;
    cycle();
    cycle();
    check("rst_req", bus.req, 0);
    check("rst_flit_valid", bus.flit_valid, 0);
    check("rst_flit_id", bus.flit_id, 0);
    check("rst_length", bus.length, 0);
    check("rst_flit_out", bus.flit_out, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_pkt_ready", bus.pkt_ready, 1);
    rst = 1'b0;

    // length 4, continuous grant and data: 001,010,010,100
    accept(12'd4);
    grant_to_send();
    run_flits(0, 4, 4, 32'hA000_0000);
    tail_done(32'hA000_0003);

    // length 0 clamps to 2: 001,100
    accept(12'd0);
    grant_to_send();
    run_flits(0, 2, 2, 32'hB000_0000);
    tail_done(32'hB000_0001);

    // length 5, grant lost for 3 cycles after the 2nd flit
    accept(12'd5);
    grant_to_send();
    run_flits(0, 2, 5, 32'hC000_0000);
    bus.grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("gap_flit_valid", bus.flit_valid, 0);
      check("gap_req", bus.req, 1);
      check("gap_data_ready", bus.data_ready, 0);
    end
    grant_to_send();
    run_flits(2, 3, 5, 32'hC000_0000);
    tail_done(32'hC000_0004);

    // length 6, reset while the 3rd flit is offered
    accept(12'd6);
    grant_to_send();
    run_flits(0, 2, 6, 32'hD000_0000);
    bus.data_in = 32'hD000_0002;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.grant      = 1'b0;
    bus.data_valid = 1'b0;
    check("midrst_req", bus.req, 0);
    check("midrst_flit_valid", bus.flit_valid, 0);
    check("midrst_flit_id", bus.flit_id, 0);
    check("midrst_pkt_ready", bus.pkt_ready, 1);
    accept(12'd2);
    grant_to_send();
    run_flits(0, 2, 2, 32'hE000_0000);
    tail_done(32'hE000_0001);

    // length 4, data_valid low for 2 cycles after the header
    accept(12'd4);
    grant_to_send();
    run_flits(0, 1, 4, 32'hF000_0000);
    bus.data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("dstall_flit_valid", bus.flit_valid, 0);
      check("dstall_flit_id", bus.flit_id, 0);
      check("dstall_data_ready", bus.data_ready, 1);
      check("dstall_flit_out_hold", bus.flit_out, 32'hF000_0000);
    end
    bus.data_valid = 1'b1;
    run_flits(1, 3, 4, 32'hF000_0000);
    tail_done(32'hF000_0003);

    // grant withheld for 7 cycles after req rises
    accept(12'd3);
    check("stall_cnt_at_accept", bus.stall_cnt, 0);
    for (int i = 0; i < 7; i++) cycle();
`ifdef FLIT_REQ_STALL_CNT_EN
    check("stall_cnt_7", bus.stall_cnt, 7);
`else
    check("stall_cnt_tied", bus.stall_cnt, 0);
`endif
    check("stall_req_held", bus.req, 1);
    grant_to_send();
    run_flits(0, 3, 3, 32'h1234_0000);
    tail_done(32'h1234_0002);
    accept(12'd2);
    check("stall_cnt_cleared", bus.stall_cnt, 0);
    grant_to_send();
    run_flits(0, 2, 2, 32'h5678_0000);
    tail_done(32'h5678_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
